nwc_input_loader: RTL and testbench

Upstream feeder for `nwc_processor`. Accepts a beat stream of coefficient pairs (one coefficient of polynomial A and one of polynomial B per beat) and packs two consecutive beats into the 60-bit words the processor loads. It drives the processor's `write_enable` for exactly `N_WORDS` words, issues the one-cycle `start` pulse, and holds off new input until the processor reports `computation_finished`.

---
 rtl/nwc_input_loader.sv | 158 +++++++++++++++
 tb/tb_nwc_input_loader.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nwc_input_loader.sv
// Packs A/B coefficient beat pairs into 2*COE_W-bit processor words, then issues start and waits for completion.
// Words appear one cycle after the odd beat; in_ready drops from START until computation_finished. Option: NWC_LOADER_RANGE_CHECK_EN.
module nwc_input_loader #(
  parameter int          N_WORDS = 2048,
  parameter int          COE_W   = 30,
  parameter int unsigned Q       = 998244353
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COE_W-1:0]   in_a,
  input  logic [COE_W-1:0]   in_b,
  output logic [2*COE_W-1:0] data_out0,
  output logic [2*COE_W-1:0] data_out1,
  output logic               write_enable,
  output logic               start,
  input  logic               proc_ready,
  input  logic               computation_finished,
  output logic               busy,
  output logic               err_range
);

  localparam int CNT_W = $clog2(N_WORDS) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_START = 2'd2;
  localparam logic [1:0] S_BUSY  = 2'd3;

  logic [1:0]         r_state;
  logic               r_half;
  logic [CNT_W-1:0]   r_cnt;
  logic [COE_W-1:0]   r_lo_a;
  logic [COE_W-1:0]   r_lo_b;
  logic [2*COE_W-1:0] r_out0;
  logic [2*COE_W-1:0] r_out1;
  logic               r_we;
  logic               r_start;

  logic               w_in_ready;
  logic               w_acc;
  logic [COE_W-1:0]   w_a;
  logic [COE_W-1:0]   w_b;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_last_word;

  // Gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst_n) begin
      case (r_state)
        S_IDLE:  w_in_ready = proc_ready;
        S_LOAD:  w_in_ready = 1'b1;
        default: w_in_ready = 1'b0;
      endcase
    end
  end

  assign w_acc       = in_valid && w_in_ready;
  assign w_cnt_nxt   = r_cnt + CNT_W'(1);
  assign w_last_word = w_acc && r_half && (w_cnt_nxt == CNT_W'(N_WORDS));

`ifdef NWC_LOADER_RANGE_CHECK_EN
  localparam logic [COE_W-1:0] Q_C = COE_W'(Q);

  logic r_err;
  logic w_a_hi;
  logic w_b_hi;

  // A single subtraction suffices: inputs are assumed below 2*Q.
  assign w_a_hi = (in_a >= Q_C);
  assign w_b_hi = (in_b >= Q_C);
  assign w_a    = w_a_hi ? (in_a - Q_C) : in_a;
  assign w_b    = w_b_hi ? (in_b - Q_C) : in_b;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_acc && (w_a_hi || w_b_hi)) begin
      r_err <= 1'b1;
    end
  end

  assign err_range = r_err;
`else
  logic [COE_W-1:0] w_unused_q;

  assign w_unused_q = COE_W'(Q);
  assign w_a        = in_a;
  assign w_b        = in_b;
  assign err_range  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_half  <= 1'b0;
      r_cnt   <= '0;
      r_lo_a  <= '0;
      r_lo_b  <= '0;
      r_out0  <= '0;
      r_out1  <= '0;
      r_we    <= 1'b0;
      r_start <= 1'b0;
    end else begin
      r_we    <= 1'b0;
      r_start <= 1'b0;

      if (w_acc) begin
        r_half <= ~r_half;
        if (!r_half) begin
          r_lo_a <= w_a;
          r_lo_b <= w_b;
        end else begin
          r_out0 <= {w_a, r_lo_a};
          r_out1 <= {w_b, r_lo_b};
          r_we   <= 1'b1;
          r_cnt  <= w_cnt_nxt;
        end
      end

      // start is registered out of START so it lands one cycle after the final write.
      case (r_state)
        S_IDLE: begin
          if (w_acc) begin
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (w_last_word) begin
            r_state <= S_START;
          end
        end
        S_START: begin
          r_start <= 1'b1;
          r_state <= S_BUSY;
        end
        S_BUSY: begin
          if (computation_finished) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_half  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready     = w_in_ready;
  assign data_out0    = r_out0;
  assign data_out1    = r_out1;
  assign write_enable = r_we;
  assign start        = r_start;
  assign busy         = (r_state != S_IDLE);

endmodule

// File: tb/tb_nwc_input_loader.sv
// Scoreboard bench for nwc_input_loader: expected words queued as beats are driven, popped on write_enable.
module tb_nwc_input_loader;

  localparam int          NW = 2048;
  localparam int          CW = 30;
  localparam int unsigned QV = 998244353;
`ifdef NWC_LOADER_RANGE_CHECK_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CW-1:0]   in_a;
  logic [CW-1:0]   in_b;
  logic [2*CW-1:0] data_out0;
  logic [2*CW-1:0] data_out1;
  logic            write_enable;
  logic            start;
  logic            proc_ready;
  logic            computation_finished;
  logic            busy;
  logic            err_range;

  always #5 clk = ~clk;

  nwc_input_loader #(.N_WORDS(NW), .COE_W(CW), .Q(QV)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_a                 (in_a),
    .in_b                 (in_b),
    .data_out0            (data_out0),
    .data_out1            (data_out1),
    .write_enable         (write_enable),
    .start                (start),
    .proc_ready           (proc_ready),
    .computation_finished (computation_finished),
    .busy                 (busy),
    .err_range            (err_range)
  );

  int              n_tot   = 0;
  int              n_bad   = 0;
  int              n_we    = 0;
  int              n_start = 0;
  int              cyc     = 0;
  int              last_we = -10;
  logic [2*CW-1:0] q0[$];
  logic [2*CW-1:0] q1[$];
  logic [2*CW-1:0] h0, h1, e0, e1;
  logic            rst_prev;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [CW-1:0] red(input logic [CW-1:0] c);
`ifdef NWC_LOADER_RANGE_CHECK_EN
    if ({2'b00, c} >= QV) return c - CW'(QV);
    return c;
`else
    return c;
`endif
  endfunction

  // Drives n beats (a=i, b=4095-i); gaps idles every third cycle and pokes
  // computation_finished early, bad0 makes beat 0 of A out of range.
  task automatic run_load(input int n, input bit gaps, input bit bad0);
    int            i    = 0;
    int            c    = 0;
    bit            pend = 1'b0;
    logic [CW-1:0] a, b;
    logic [CW-1:0] lo_a = '0;
    logic [CW-1:0] lo_b = '0;
    while (i < n) begin
      @(posedge clk); #1;
      computation_finished = gaps && (c < 6);
      if (gaps && (c % 3 == 2)) begin
        in_valid = 1'b0;
      end else begin
        a = (bad0 && i == 0) ? 30'd998244360 : CW'(i);
        b = CW'(4095 - i);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        if (i % 2 == 0) begin
          lo_a = red(a);
          lo_b = red(b);
        end else begin
          q0.push_back({red(a), lo_a});
          q1.push_back({red(b), lo_b});
        end
        i++;
      end
      c++;
      @(negedge clk);
      if (in_valid) check("in_ready_load", in_ready, 1);
      if (pend) begin
        check("err_range_next", err_range, ERR_EXP);
        pend = 1'b0;
      end
      if (bad0 && in_valid && i == 1) pend = 1'b1;
    end
    @(posedge clk); #1;
    in_valid             = 1'b0;
    computation_finished = 1'b0;
  endtask

  task automatic finish_load(input string tag, input int wb, input int sb);
    repeat (6) @(posedge clk);
    @(negedge clk);
    check({tag, "_writes"}, n_we - wb, NW);
    check({tag, "_starts"}, n_start - sb, 1);
    check({tag, "_sb_empty"}, q0.size(), 0);
    check({tag, "_busy"}, busy, 1);
  endtask

  task automatic complete();
    @(posedge clk); #1;
    computation_finished = 1'b1;
    @(negedge clk);
    check("busy_before_cf", busy, 1);
    @(posedge clk); #1;
    computation_finished = 1'b0;
    @(negedge clk);
    check("busy_after_cf", busy, 0);
    check("in_ready_idle", in_ready, 1);
  endtask

  initial begin
    int wb, sb;
    rst_n                = 1'b0;
    in_valid             = 1'b1;
    in_a                 = 30'd5;
    in_b                 = 30'd9;
    proc_ready           = 1'b1;
    computation_finished = 1'b0;
    rst_prev             = 1'b0;
    h0                   = '0;
    h1                   = '0;

    // Monitor: pops the scoreboard on every write, checks hold and start spacing.
    fork
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_prev) begin
          h0 = '0;
          h1 = '0;
        end
        if (write_enable === 1'b1) begin
          n_we++;
          last_we = cyc;
          if (q0.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e0 = q0.pop_front();
            e1 = q1.pop_front();
            check("data_out0", data_out0, e0);
            check("data_out1", data_out1, e1);
            h0 = e0;
            h1 = e1;
          end
        end else begin
          check("hold_out0", data_out0, h0);
          check("hold_out1", data_out1, h1);
        end
        if (start === 1'b1) begin
          n_start++;
          check("start_after_write", cyc - last_we, 1);
        end
        rst_prev = rst_n;
      end
    join_none

    repeat (3) begin
      @(negedge clk);
      check("rst_we", write_enable, 0);
      check("rst_start", start, 0);
      check("rst_in_ready", in_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_err", err_range, 0);
      check("rst_out0", data_out0, 0);
      check("rst_out1", data_out1, 0);
    end
    @(posedge clk); #1;
    rst_n    = 1'b1;
    in_valid = 1'b0;
    check("rst_no_write", n_we, 0);

    wb = n_we; sb = n_start;
    run_load(4096, 1'b0, 1'b0);
    finish_load("full", wb, sb);

    in_valid = 1'b1;
    repeat (50) begin
      @(negedge clk);
      check("in_ready_busy", in_ready, 0);
      check("busy_hold", busy, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    complete();

    wb = n_we; sb = n_start;
    run_load(4096, 1'b1, 1'b0);
    finish_load("gaps", wb, sb);
    complete();

    run_load(1001, 1'b0, 1'b1);
    @(negedge clk);
    check("err_sticky", err_range, ERR_EXP);
    check("mid_sb_empty", q0.size(), 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_err", err_range, 0);
    check("mid_rst_out0", data_out0, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    wb = n_we; sb = n_start;
    run_load(4096, 1'b0, 1'b0);
    finish_load("fresh", wb, sb);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete in time");
    $fatal(1);
  end

endmodule
